// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I/RV64 load/store unit with req/ack data bus and sub-word lanes.
// Define LSU_TIMEOUT_EN to abort bus cycles after TIMEOUT unacknowledged cycles.
module rv32i_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_func3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                stall,
   output logic                busReq,
   output logic                busWe,
   output logic [DATA_W/8-1:0] busBe,
   output logic [ADDR_W-1:0]   busAddr,
   output logic [DATA_W-1:0]   busWData,
   input  logic [DATA_W-1:0]   busRData,
   input  logic                busAck
);
   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);

   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_w
      $error("rv32i_lsu: DATA_W must be 32 or 64");
   end
   if (TIMEOUT < 1) begin : g_bad_to
      $error("rv32i_lsu: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [LB-1:0]     lane_q, lane_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NB-1:0]     be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              tmo;

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // Last unacked cycle of the budget: leave BUS on this edge.
   assign tmo = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = '0;
      if (state_q == BUS && !busAck) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign tmo = 1'b0;
`endif

   logic [2:0]    mask;
   logic [7:0]    be_base;
   logic          legal;
   logic          mis;
   logic [LB-1:0] lane_in;

   assign lane_in = req_addr[LB-1:0];

   always_comb begin
      mask    = 3'd0;
      be_base = 8'h00;
      legal   = 1'b1;
      case (req_func3)
         3'b000: be_base = 8'h01;
         3'b001: begin be_base = 8'h03; mask = 3'd1; end
         3'b010: begin be_base = 8'h0F; mask = 3'd3; end
         3'b011: begin
            be_base = 8'hFF; mask = 3'd7;
            legal = (DATA_W == 64);
         end
         3'b100: begin be_base = 8'h01; legal = !req_we; end
         3'b101: begin
            be_base = 8'h03; mask = 3'd1;
            legal = !req_we;
         end
         3'b110: begin
            be_base = 8'h0F; mask = 3'd3;
            legal = !req_we && (DATA_W == 64);
         end
         default: legal = 1'b0;
      endcase
      mis = |(req_addr[2:0] & mask) || !legal;
   end

   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] ext;

   assign sh = busRData >> {lane_q, 3'b000};

   always_comb begin
      ext = '0;
      case (f3_q)
         3'b000:  ext = DATA_W'($signed(sh[7:0]));
         3'b001:  ext = DATA_W'($signed(sh[15:0]));
         3'b010:  ext = DATA_W'($signed(sh[31:0]));
         3'b011:  ext = sh;
         3'b100:  ext = DATA_W'(sh[7:0]);
         3'b101:  ext = DATA_W'(sh[15:0]);
         3'b110:  ext = DATA_W'(sh[31:0]);
         default: ext = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      lane_d  = lane_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: if (req_valid) begin
            we_d    = req_we;
            f3_d    = req_func3;
            lane_d  = lane_in;
            addr_d  = {req_addr[ADDR_W-1:LB], LB'(0)};
            be_d    = NB'(be_base) << lane_in;
            wdata_d = req_wdata << {lane_in, 3'b000};
            rdata_d = '0;
            err_d   = mis;
            state_d = mis ? RESP : BUS;
         end
         BUS: if (busAck) begin
            rdata_d = we_q ? '0 : ext;
            state_d = RESP;
         end else if (tmo) begin
            err_d   = 1'b1;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         lane_q  <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode from state so an async reset drops them at once.
   assign req_ready = (state_q == IDLE);
   assign stall     = (state_q != IDLE);
   assign busReq    = (state_q == BUS);
   assign busWe     = busReq && we_q;
   assign busBe     = busReq ? be_q : '0;
   assign busAddr   = busReq ? addr_q : '0;
   assign busWData  = busReq ? wdata_q : '0;
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_err   = rsp_valid && err_q;
endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: randomized and directed checks of rv32i_lsu (DATA_W=32)
// against a byte-lane arithmetic reference model.
module tb_rv32i_lsu;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_func3 = 3'd0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          stall;
   logic          busReq;
   logic          busWe;
   logic [3:0]    busBe;
   logic [AW-1:0] busAddr;
   logic [DW-1:0] busWData;
   logic [DW-1:0] busRData = '0;
   logic          busAck = 1'b0;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   rv32i_lsu #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_func3(req_func3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .stall(stall),
      .busReq(busReq), .busWe(busWe), .busBe(busBe),
      .busAddr(busAddr), .busWData(busWData),
      .busRData(busRData), .busAck(busAck)
   );

   // Access size in bytes, 0 when the funct3/direction pair is not legal.
   function automatic int acc_size(input bit we, input logic [2:0] f3);
      case (f3)
         3'b000:  return 1;
         3'b001:  return 2;
         3'b010:  return 4;
         3'b100:  return we ? 0 : 1;
         3'b101:  return we ? 0 : 2;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_err(input bit we, input logic [2:0] f3,
                                 input logic [31:0] a);
      int s;
      s = acc_size(we, f3);
      if (s == 0) return 1'b1;
      return (a % s) != 0;
   endfunction

   function automatic logic [3:0] exp_be(input bit we, input logic [2:0] f3,
                                         input logic [31:0] a);
      int s;
      int unsigned v;
      s = acc_size(we, f3);
      v = ((1 << s) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] rd);
      int s;
      longint unsigned v;
      longint unsigned m;
      s = acc_size(1'b0, f3);
      v = 64'(rd) / (64'd1 << (8 * (a % 4)));
      m = (64'd1 << (8 * s)) - 1;
      v = v & m;
      if (f3[2] == 1'b0 && ((v >> (8 * s - 1)) & 1) == 1) v = v | ~m;
      return v[31:0];
   endfunction

   task automatic run_txn(input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
      bit err;
      logic [3:0] be;
      logic [31:0] ewd;
      logic [31:0] erd;
      err = is_err(we, f3, a);
      be  = exp_be(we, f3, a);
      ewd = 32'(64'(wd) * (64'd1 << (8 * (a % 4))));
      erd = (we || err) ? 32'd0 : exp_load(f3, a, rd);
      checks++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL txn_ready act=%b exp=1", req_ready);
      end
      req_valid = 1'b1; req_we = we; req_func3 = f3;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom;
      if (err) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
             rsp_rdata !== 32'd0 || busReq !== 1'b0) begin
            fails++;
            $display("FAIL txn_err a=%h f3=%0d act v=%b e=%b d=%h req=%b exp 1 1 0 0",
                     a, f3, rsp_valid, rsp_err, rsp_rdata, busReq);
         end
      end else begin
         for (int i = 0; i <= waits; i++) begin
            checks++;
            if (busReq !== 1'b1 || busWe !== we || busBe !== be ||
                busAddr !== (a & ~32'd3) || stall !== 1'b1 ||
                rsp_valid !== 1'b0 || (we && busWData !== ewd)) begin
               fails++;
               $display("FAIL txn_bus a=%h act req=%b we=%b be=%h ad=%h wd=%h exp 1 %b %h %h %h",
                        a, busReq, busWe, busBe, busAddr, busWData,
                        we, be, a & ~32'd3, ewd);
            end
            busAck = (i == waits);
            busRData = (i == waits) ? rd : $urandom;
            @(negedge clk);
         end
         busAck = 1'b0;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== erd ||
             busReq !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL txn_rsp a=%h f3=%0d act v=%b e=%b d=%h exp 1 0 %h",
                     a, f3, rsp_valid, rsp_err, rsp_rdata, erd);
         end
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
         fails++;
         $display("FAIL txn_idle act v=%b rdy=%b st=%b exp 0 1 0",
                  rsp_valid, req_ready, stall);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busReq !== 1'b0 ||
          stall !== 1'b0 || busBe !== 4'd0 || rsp_rdata !== 32'd0) begin
         fails++;
         $display("FAIL reset act rdy=%b v=%b req=%b st=%b be=%h exp 1 0 0 0 0",
                  req_ready, rsp_valid, busReq, stall, busBe);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sw();
      run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
   endtask

   task automatic test_lb();
      run_txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0);
      run_txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0);
      run_txn(1'b0, 3'b001, 32'h202, 32'h0, 32'h9ABC1234, 1);
      run_txn(1'b0, 3'b101, 32'h202, 32'h0, 32'h9ABC1234, 0);
   endtask

   task automatic test_sh_wait();
      run_txn(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 3);
   endtask

   task automatic test_misaligned();
      run_txn(1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 0);
      run_txn(1'b1, 3'b001, 32'h403, 32'h1, 32'h0, 0);
      run_txn(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0);
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010;
      req_addr = 32'h40; busAck = 1'b1; busRData = 32'h11112222;
      @(negedge clk);
      checks++;
      if (busReq !== 1'b1) begin
         fails++;
         $display("FAIL b2b_bus1 act=%b exp=1", busReq);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11112222 ||
          req_ready !== 1'b0) begin
         fails++;
         $display("FAIL b2b_rsp1 act v=%b d=%h rdy=%b exp 1 11112222 0",
                  rsp_valid, rsp_rdata, req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || busReq !== 1'b0 || rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_idle act rdy=%b req=%b v=%b exp 1 0 0",
                  req_ready, busReq, rsp_valid);
      end
      @(negedge clk);
      req_valid = 1'b0;
      busRData = 32'h33334444;
      checks++;
      if (busReq !== 1'b1) begin
         fails++;
         $display("FAIL b2b_bus2 act=%b exp=1", busReq);
      end
      @(negedge clk);
      busAck = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h33334444) begin
         fails++;
         $display("FAIL b2b_rsp2 act v=%b d=%h exp 1 33334444",
                  rsp_valid, rsp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int n;
      int exp_n;
`ifdef LSU_TIMEOUT_EN
      exp_n = TO;
`else
      exp_n = 120;
`endif
      req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010;
      req_addr = 32'h500;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 120 && busReq === 1'b1 && stall === 1'b1; i++) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != exp_n) begin
         fails++;
         $display("FAIL tmo_len act=%0d exp=%0d", n, exp_n);
      end
`ifndef LSU_TIMEOUT_EN
      busAck = 1'b1; busRData = 32'h55AA55AA;
      @(negedge clk);
      busAck = 1'b0;
`endif
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== (exp_n == TO) ||
          rsp_rdata !== ((exp_n == TO) ? 32'd0 : 32'h55AA55AA)) begin
         fails++;
         $display("FAIL tmo_rsp act v=%b e=%b d=%h", rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_bus();
      req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010;
      req_addr = 32'h600; req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (busReq !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1 ||
          busWData !== 32'd0) begin
         fails++;
         $display("FAIL rst_mid act req=%b st=%b rdy=%b wd=%h exp 0 0 1 0",
                  busReq, stall, req_ready, busWData);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_txn(1'b0, 3'b010, 32'h0, 32'h0, 32'h87654321, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 80; k++) begin
         run_txn(1'($urandom), 3'($urandom), $urandom, $urandom,
                 $urandom, int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_lb();
      test_sh_wait();
      test_misaligned();
      test_back_to_back();
      test_timeout();
      test_reset_mid_bus();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
